pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised chain of STAGES pipeline registers, each WIDTH bits plus a valid bit.
//  Supports per-stage stall, per-stage flush and valid/ready backpressure with bubble collapse.
//  Replaces hand-instantiated inter-stage registers, e.g. IF/ID, ID/EX and EX/MEM, with one block.
//  Stage 0 is the input side; stage STAGES-1 drives the output.
// PARAMETERS
//  WIDTH    200  payload bits per stage
//  STAGES   3    number of register stages (>=1)
//  COLLAPSE 1    1: per-stage ready chain (bubbles squeezed out); 0: lockstep, one global enable
// PORTS
//  Clk       in   1                     clock, all state on posedge
//  rst       in   1                     synchronous, active-high reset
//  in_valid  in   1                     upstream item present
//  in_data   in   WIDTH                 upstream payload
//  in_ready  out  1                     chain accepts in_data this cycle
//  stall     in   STAGES                stall[i]=1: stage i holds its contents
//  flush     in   STAGES                flush[i]=1: stage i register zeroed at next edge
//  out_valid out  1                     valid_q[STAGES-1]
//  out_data  out  WIDTH                 data_q[STAGES-1]
//  out_ready in   1                     downstream consumes the output item
//  occ       out  $clog2(STAGES+1)      number of valid stages (popcount of valid_q, combinational)
// BEHAVIOUR
//  - Reset: at a posedge with rst=1, all valid_q=0 and data_q=0. Then out_valid=0, out_data=0, occ=0.
//  - Priority at each stage edge: rst > flush[i] > load > hold.
//  - Upstream of stage i: stage i-1 registers; for stage 0 it is (in_valid, in_data).
//  - COLLAPSE=1:
//    - ready[STAGES]=out_ready.
//    - ready[i] = !stall[i] & (!valid_q[i] | ready[i+1]).
//    - in_ready=ready[0]. The chain is combinational from out_ready to in_ready; no registered skid.
//  - COLLAPSE=0:
//    - adv = ~|stall & (out_ready | ~out_valid). ready[i]=adv for all i; in_ready=adv.
//  - Load (ready[i]=1, no flush/rst):
//    - Upstream valid: valid_q[i]<=1, data_q[i]<=upstream data.
//    - Upstream invalid (bubble): valid_q[i]<=0, data_q[i]<=0.
//    - Invalid stages always hold data 0.
//  - Hold (ready[i]=0): stage i keeps valid_q/data_q.
//    - If stage i+1 loads while stage i holds, stage i+1 receives a bubble, not a duplicate.
//  - Flush:
//    - flush[i] zeroes register i at the edge, including any item arriving from stage i-1, which is lost.
//    - The item leaving stage i that cycle still advances into i+1 unless flush[i+1].
//    - flush does not alter the ready[] or in_ready computation.
//    - All-ones flush empties the chain in one cycle.
//  - Output transfer: when out_valid & out_ready. Dropping out_valid without a transfer is only possible via flush/rst.
//  - Latency:
//    - With no stalls and out_ready=1, an item accepted at edge k is on out_data after edge k+STAGES-1.
//    - That is STAGES cycles from presentation on in_data.
//    - Throughput is 1 item/cycle.
//  - Capacity: STAGES items. With out_ready=0 and COLLAPSE=1, in_ready falls only when all stages are valid.
//  - Simultaneous events:
//    - rst with anything: full clear.
//    - stall[i] with flush[i]: flush wins.
//    - stall with out_ready=1: upstream stages still drain into downstream free slots.
//  - No X propagation: every register is defined after the first rst edge.
// TESTING (WIDTH=8, STAGES=3, COLLAPSE=1 unless noted)
//  1. Reset: hold rst 2 cycles, stall=0, flush=0, out_ready=1.
//     -> out_valid=0, out_data=0, occ=0, in_ready=1.
//  2. Stream: push 0x11,0x22,0x33 on consecutive edges, out_ready=1.
//     -> out_data 0x11/0x22/0x33 on 3 consecutive cycles.
//     -> 0x11 visible after the 3rd edge; occ peaks at 3.
//  3. Backpressure with bubble collapse: out_ready=0, push A, idle 1 cycle, push B, then offer C, D.
//     -> stage2=A, stage1=B, stage0=C, occ=3, in_ready=0; D not accepted.
//     -> out_ready=1 then yields A, B, C in order.
//  4. Mid stall: chain holds A,B,C in stages 2,1,0; stall=3'b010 for 1 cycle, out_ready=1.
//     -> A leaves; stage2=bubble (valid 0, data 0); B and C hold.
//     -> in_ready=0 that cycle.
//  5. Flush: chain holds A,B,C in stages 2,1,0; flush=3'b011, in_valid=1 with D, out_ready=1.
//     -> next cycle stage2=B, stage1=0, stage0=0; D dropped; occ=1.
//  6. Lockstep and reset: with COLLAPSE=0, stall=3'b001 -> all stages hold, in_ready=0.
//     -> Then rst=1 with flush=3'b100 mid-stream -> full clear next edge.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of pipeline registers, each carrying a payload and a valid bit.
// The chain supports per-stage stall, per-stage flush and valid/ready backpressure.
// With COLLAPSE=1 a per-stage ready chain squeezes bubbles out of the pipe.
// With COLLAPSE=0 all stages advance together on one global enable.
// Stage 0 is the input side and stage STAGES-1 drives the output.
module pipe_reg_chain #(
  parameter int unsigned WIDTH    = 200,
  parameter int unsigned STAGES   = 3,
  parameter bit          COLLAPSE = 1'b1
) (
  input  logic                          Clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic [STAGES-1:0]             stall,
  input  logic [STAGES-1:0]             flush,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [$clog2(STAGES+1)-1:0]   occ
);

  localparam int unsigned OccW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];

  // ready[i]=1 means stage i loads from upstream at the next edge
  logic [STAGES:0]   ready;
  logic              adv;

  // Upstream view of each stage; a holding stage presents a bubble downstream
  logic [STAGES-1:0] up_valid;
  logic [WIDTH-1:0]  up_data [STAGES];

  // Ready chain: ripple from out_ready in collapse mode, one global enable in lockstep mode
  always_comb begin
    ready = '0;
    adv   = 1'b0;
    if (COLLAPSE) begin
      ready[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
        ready[i] = !stall[i] & (!valid_q[i] | ready[i+1]);
      end
    end else begin
      adv   = ~|stall & (out_ready | ~valid_q[STAGES-1]);
      ready = {(STAGES + 1){adv}};
    end
  end

  // Upstream source per stage; an item only moves on if its own stage is loading
  always_comb begin
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1] & ready[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  // Next state per stage: flush > load > hold; invalid stages carry zero data
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      if (flush[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = '0;
      end else if (ready[i]) begin
        valid_d[i] = up_valid[i];
        data_d[i]  = up_valid[i] ? up_data[i] : '0;
      end
    end
  end

  // Stage registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Occupancy is the popcount of the valid bits
  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ = occ + OccW'(valid_q[i]);
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a collapsing instance and a lockstep instance
// share the same stimulus; the lockstep outputs are only checked in the lockstep test.
module tb_pipe_reg_chain;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;

  logic         Clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [S-1:0] stall;
  logic [S-1:0] flush;
  logic         out_ready;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occ;

  logic         ls_in_ready, ls_out_valid;
  logic [W-1:0] ls_out_data;
  logic [1:0]   ls_occ;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1'b1)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

  pipe_reg_chain #(.WIDTH(W), .STAGES(S), .COLLAPSE(1'b0)) dut_ls (
    .Clk       (Clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (ls_in_ready),
    .stall     (stall),
    .flush     (flush),
    .out_valid (ls_out_valid),
    .out_data  (ls_out_data),
    .out_ready (out_ready),
    .occ       (ls_occ)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, then settle away from it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    stall = '0; flush = '0; out_ready = 1'b1;

    // 1. Reset
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_occ",       32'(occ),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // 2. Stream at full rate
    push(8'h11);
    push(8'h22);
    check("stream_not_yet", 32'(out_valid), 32'd0);
    push(8'h33);
    in_valid = 1'b0;
    check("stream_d0",  32'(out_data), 32'h11);
    check("stream_v0",  32'(out_valid), 32'd1);
    check("stream_occ", 32'(occ), 32'd3);
    tick();
    check("stream_d1", 32'(out_data), 32'h22);
    tick();
    check("stream_d2", 32'(out_data), 32'h33);
    tick();
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_occ0",  32'(occ), 32'd0);

    // 3. Backpressure with bubble collapse
    out_ready = 1'b0;
    push(8'hA1);
    in_valid = 1'b0;
    tick();
    push(8'hB2);
    push(8'hC3);
    in_valid = 1'b1; in_data = 8'hD4;
    #1;
    check("bp_full_occ",  32'(occ), 32'd3);
    check("bp_in_ready",  32'(in_ready), 32'd0);
    tick();
    check("bp_hold_occ",  32'(occ), 32'd3);
    check("bp_head",      32'(out_data), 32'hA1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_out_b", 32'(out_data), 32'hB2);
    tick();
    check("bp_out_c", 32'(out_data), 32'hC3);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // 4. Mid-stage stall
    out_ready = 1'b0;
    push(8'hA1); push(8'hB2); push(8'hC3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    stall = 3'b010;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    tick();
    stall = '0;
    check("stall_bubble_v", 32'(out_valid), 32'd0);
    check("stall_bubble_d", 32'(out_data), 32'd0);
    check("stall_occ",      32'(occ), 32'd2);
    tick();
    check("stall_out_b", 32'(out_data), 32'hB2);
    tick();
    check("stall_out_c", 32'(out_data), 32'hC3);
    tick();
    check("stall_empty", 32'(occ), 32'd0);

    // 5. Flush stages 0 and 1 while A leaves
    out_ready = 1'b0;
    push(8'hA1); push(8'hB2); push(8'hC3);
    out_ready = 1'b1;
    flush = 3'b011;
    push(8'hD4);
    flush = '0;
    in_valid = 1'b0;
    check("flush_out_b", 32'(out_data), 32'hB2);
    check("flush_v",     32'(out_valid), 32'd1);
    check("flush_occ",   32'(occ), 32'd1);
    tick();
    check("flush_empty", 32'(out_valid), 32'd0);
    check("flush_occ0",  32'(occ), 32'd0);

    // 6. Lockstep hold on a single stall bit, then reset with flush
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push(8'h61); push(8'h62); push(8'h63);
    check("ls_head", 32'(ls_out_data), 32'h61);
    in_data = 8'h64;
    stall = 3'b001;
    #1;
    check("ls_in_ready", 32'(ls_in_ready), 32'd0);
    tick();
    check("ls_hold_d",   32'(ls_out_data), 32'h61);
    check("ls_hold_occ", 32'(ls_occ), 32'd3);
    stall = '0;
    rst = 1'b1;
    flush = 3'b100;
    tick();
    rst = 1'b0;
    flush = '0;
    in_valid = 1'b0;
    #1;
    check("ls_rst_occ",  32'(ls_occ), 32'd0);
    check("ls_rst_v",    32'(ls_out_valid), 32'd0);
    check("ls_rst_d",    32'(ls_out_data), 32'd0);
    check("col_rst_occ", 32'(occ), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
